// File: rtl/energy_pkg.sv
// Shared types and defaults for the energy manager input path.
package energy_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;  // 10 ms at 25 MHz
  localparam int DEFAULT_SYNC_STAGES     = 2;

  typedef enum logic {
    BATT_FULL = 1'b0,
    BATT_LOW  = 1'b1
  } batt_state_t;

  // One-hot demand word: bit 2 = HIGH, bit 1 = LOW, bit 0 = IDLE.
  typedef enum logic [2:0] {
    DEMAND_IDLE = 3'b001,
    DEMAND_LOW  = 3'b010,
    DEMAND_HIGH = 3'b100
  } demand_t;

  // Priority decode HIGH > LOW > IDLE; an all-zero input falls through to IDLE.
  function automatic demand_t decode_demand(input logic high, input logic low);
    if (high)     return DEMAND_HIGH;
    else if (low) return DEMAND_LOW;
    else          return DEMAND_IDLE;
  endfunction

  // True when more than one of the three demand lines is asserted.
  function automatic logic multi_demand(input logic low, input logic high, input logic idle);
    return ({1'b0, low} + {1'b0, high} + {1'b0, idle}) > 2'd1;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// One input channel: multi-flop synchronizer followed by a stable-count debouncer.
module debounce_sync
  import energy_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic fell
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain; resets to the idle level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling the pre-edge value,
    // which is what makes this a shift chain rather than a single wire.
    if (reset) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= RESET_LEVEL;
      cnt    <= '0;
      fell   <= 1'b0;
    end else begin
      fell <= 1'b0;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s;
        cnt    <= '0;
        fell   <= stable & ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/energy_input_conditioner.sv
// Conditions raw GPIO for the energy manager: debounced demand decode, brake, battery toggle.
module energy_input_conditioner
  import energy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_demand_low,
  input  logic raw_demand_high,
  input  logic raw_idle,
  input  logic raw_braking,
  input  logic raw_battery_btn,
  output logic p_demand_low,
  output logic p_demand_high,
  output logic p_idle,
  output logic is_braking,
  output logic battery_low,
  output logic battery_high,
  output logic battery_full,
  output logic demand_fault,
  output logic battery_event
);

  logic stable_low, stable_high, stable_idle, stable_braking;
  logic btn_fell;
  logic [3:0] unused_fell;
  logic       unused_btn_stable;

  demand_t     demand_q;
  batt_state_t state_q, state_d;
  logic        event_d;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0))
    u_low   (.clk(clk), .reset(reset), .raw(raw_demand_low),  .stable(stable_low),     .fell(unused_fell[0]));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0))
    u_high  (.clk(clk), .reset(reset), .raw(raw_demand_high), .stable(stable_high),    .fell(unused_fell[1]));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0))
    u_idle  (.clk(clk), .reset(reset), .raw(raw_idle),        .stable(stable_idle),    .fell(unused_fell[2]));
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0))
    u_brake (.clk(clk), .reset(reset), .raw(raw_braking),     .stable(stable_braking), .fell(unused_fell[3]));
  // Button is active low, so its idle level is 1 and a press is a falling edge.
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1))
    u_btn   (.clk(clk), .reset(reset), .raw(raw_battery_btn), .stable(unused_btn_stable), .fell(btn_fell));

  // Registered demand decode, fault flag and brake so the FSM sees glitch-free levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      demand_q     <= DEMAND_IDLE;
      demand_fault <= 1'b0;
      is_braking   <= 1'b0;
    end else begin
      demand_q     <= decode_demand(stable_high, stable_low);
      demand_fault <= multi_demand(stable_low, stable_high, stable_idle);
      is_braking   <= stable_braking;
    end
  end

  assign p_demand_high = demand_q[2];
  assign p_demand_low  = demand_q[1];
  assign p_idle        = demand_q[0];

  // Battery next state: each debounced press toggles FULL <-> LOW.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_d = state_q;
    event_d = 1'b0;
    if (btn_fell) begin
      state_d = (state_q == BATT_FULL) ? BATT_LOW : BATT_FULL;
      event_d = 1'b1;
    end
  end

  // Battery state register; the event pulse is registered alongside so both appear together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BATT_FULL;
      battery_event <= 1'b0;
    end else begin
      state_q       <= state_d;
      battery_event <= event_d;
    end
  end

  assign battery_low  = (state_q == BATT_LOW);
  assign battery_high = (state_q == BATT_FULL);
  assign battery_full = battery_high;

endmodule
